// File: rtl/rotate_seq_pkg.sv
// Shared ALU definitions: shifter command codes, rotate direction constants
// and the rotate sequencer state encoding.
package rotate_seq_pkg;

  typedef enum logic [1:0] {
    SH_SLL = 2'd0,
    SH_SRL = 2'd1,
    SH_SRA = 2'd2,
    SH_ROT = 2'd3
  } sh_cmd_e;

  localparam logic ROT_LEFT  = 1'b0;
  localparam logic ROT_RIGHT = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ROT  = 2'd1,
    ST_DONE = 2'd2
  } rot_state_e;

endpackage

// File: rtl/rotate_seq_if.sv
// Request/response bundle of the rotate sequencer: operands and start in,
// busy/done/Result out.
interface rotate_seq_if #(
  parameter int WIDTH = 16,
  parameter int CNTW  = 4
);
  logic             start;
  logic [WIDTH-1:0] A;
  logic [CNTW-1:0]  Imm;
  logic             dir;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] Result;

  modport master (output start, A, Imm, dir, input busy, done, Result);
  modport slave  (input start, A, Imm, dir, output busy, done, Result);
endinterface

// File: rtl/rotate_seq_rot1.sv
// Combinational single-position rotator; the wrapped bit re-enters at the
// opposite end so no bit is ever lost.
module rot1
  import rotate_seq_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_dir,
  output logic [WIDTH-1:0] o_data
);

  assign o_data = (i_dir == ROT_RIGHT) ? {i_data[0], i_data[WIDTH-1:1]}
                                       : {i_data[WIDTH-2:0], i_data[WIDTH-1]};

endmodule

// File: rtl/rotate_seq.sv
// Sequential rotator: one bit position per cycle, Imm cycles per operation,
// registered done pulse and Result.
module rotate_seq
  import rotate_seq_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CNTW  = $clog2(WIDTH)
) (
  input  logic         clk,
  input  logic         rst,
  rotate_seq_if.slave  bus
);

  rot_state_e       r_state, w_state_nxt;
  logic [WIDTH-1:0] r_data;
  logic [CNTW-1:0]  r_cnt;
  logic             r_dir;
  logic             r_done;
  logic [WIDTH-1:0] r_result;
  logic [WIDTH-1:0] w_rot;

  rot1 #(.WIDTH(WIDTH)) u_rot1 (
    .i_data (r_data),
    .i_dir  (r_dir),
    .o_data (w_rot)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Imm=0 skips ROT entirely so the counter is never decremented from zero.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (bus.start) w_state_nxt = (bus.Imm != '0) ? ST_ROT : ST_DONE;
      ST_ROT:  if (r_cnt == CNTW'(1)) w_state_nxt = ST_DONE;
      ST_DONE: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_data   <= '0;
      r_cnt    <= '0;
      r_dir    <= ROT_LEFT;
      r_done   <= 1'b0;
      r_result <= '0;
    end else begin
      r_done <= (r_state == ST_DONE);
      case (r_state)
        ST_IDLE: begin
          if (bus.start) begin
            r_data <= bus.A;
            r_cnt  <= bus.Imm;
            r_dir  <= bus.dir;
          end
        end
        ST_ROT: begin
          r_data <= w_rot;
          r_cnt  <= r_cnt - CNTW'(1);
        end
        ST_DONE: r_result <= r_data;
        default: ;
      endcase
    end
  end

  assign bus.busy   = (r_state != ST_IDLE);
  assign bus.done   = r_done;
  assign bus.Result = r_result;

endmodule

// File: tb/tb_rotate_seq.sv
// Randomized self-checking bench for rotate_seq against a bit-mapping
// reference model; covers reset, latency, ignored starts and back-to-back ops.
module tb_rotate_seq;
  import rotate_seq_pkg::*;

  localparam int W  = 16;
  localparam int CW = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  rotate_seq_if #(.WIDTH(W), .CNTW(CW)) bus ();

  rotate_seq #(.WIDTH(W), .CNTW(CW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int checks   = 0;
  int failures = 0;
  logic [W-1:0] exp_res = '0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%0h exp=%0h t=%0t", tag, act, exp, $time);
    end
  endtask

  // Reference: bit i moves to (i+k) mod W for left, (i-k) mod W for right.
  function automatic logic [W-1:0] ref_rot(input logic [W-1:0] a, input int k, input logic d);
    logic [W-1:0] r;
    r = '0;
    for (int i = 0; i < W; i++) begin
      if (d == ROT_LEFT) r[(i + k) % W]     = a[i];
      else               r[(i - k + W) % W] = a[i];
    end
    return r;
  endfunction

  task automatic drive_start(input logic [W-1:0] a, input logic [CW-1:0] imm, input logic d);
    @(negedge clk);
    bus.start = 1'b1;
    bus.A     = a;
    bus.Imm   = imm;
    bus.dir   = d;
  endtask

  // From the accepting edge: busy for Imm+1 cycles, then done with Result.
  task automatic finish_op(input logic [W-1:0] a, input logic [CW-1:0] imm, input logic d);
    logic [W-1:0] want;
    want = ref_rot(a, int'(imm), d);
    @(posedge clk); #1;
    chk("busy_after_start", 32'(bus.busy), 32'd1);
    chk("done_after_start", 32'(bus.done), 32'd0);
    for (int j = 1; j <= int'(imm) + 1; j++) begin
      @(negedge clk);
      bus.start = 1'($urandom);
      bus.A     = W'($urandom);
      bus.Imm   = CW'($urandom);
      bus.dir   = 1'($urandom);
      @(posedge clk); #1;
      if (j <= int'(imm)) begin
        chk("busy_during", 32'(bus.busy), 32'd1);
        chk("done_early",  32'(bus.done), 32'd0);
        chk("result_held", 32'(bus.Result), 32'(exp_res));
      end else begin
        chk("done_pulse",  32'(bus.done), 32'd1);
        chk("busy_at_done", 32'(bus.busy), 32'd0);
        chk("result",      32'(bus.Result), 32'(want));
      end
    end
    exp_res = want;
  endtask

  task automatic run_op(input logic [W-1:0] a, input logic [CW-1:0] imm, input logic d);
    drive_start(a, imm, d);
    finish_op(a, imm, d);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      bus.start = 1'b0;
      @(posedge clk); #1;
      chk("idle_done", 32'(bus.done), 32'd0);
      chk("idle_busy", 32'(bus.busy), 32'd0);
      chk("idle_result", 32'(bus.Result), 32'(exp_res));
    end
  endtask

  initial begin
    rst       = 1'b1;
    bus.start = 1'b1;
    bus.A     = 16'h8001;
    bus.Imm   = 4'd1;
    bus.dir   = ROT_LEFT;
    #1;
    chk("rst_busy",   32'(bus.busy), 32'd0);
    chk("rst_done",   32'(bus.done), 32'd0);
    chk("rst_result", 32'(bus.Result), 32'd0);
    #11 rst = 1'b0;
    // First rising edge after deassertion must accept the start.
    finish_op(16'h8001, 4'd1, ROT_LEFT);
    idle(2);

    run_op(16'h8001, 4'd4, ROT_RIGHT);
    idle(1);
    run_op(16'hBEEF, 4'd0, ROT_RIGHT);
    idle(1);
    run_op(16'h1234, 4'd15, ROT_LEFT);
    idle(1);

    // Abort mid-ROT: outputs clear immediately, no done afterwards.
    drive_start(16'h5A5A, 4'd8, ROT_LEFT);
    @(posedge clk);
    @(negedge clk); bus.start = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("abort_busy",   32'(bus.busy), 32'd0);
    chk("abort_done",   32'(bus.done), 32'd0);
    chk("abort_result", 32'(bus.Result), 32'd0);
    exp_res = '0;
    @(negedge clk); rst = 1'b0;
    idle(12);
    run_op(16'h00FF, 4'd8, ROT_LEFT);

    // Back-to-back: next start driven straight after the done cycle.
    run_op(16'h0001, 4'd3, ROT_RIGHT);
    idle(1);

    for (int n = 0; n < 150; n++) begin
      run_op(W'($urandom), CW'($urandom), 1'($urandom));
      if ($urandom_range(0, 2) != 0) idle(int'($urandom_range(1, 2)));
    end
    idle(1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
